// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the atomic-memory sequencer:
// A-extension funct5 encodings and the sequencer state type.
package riscv_pkg;

   localparam logic [4:0] F5_ADD  = 5'b00000;
   localparam logic [4:0] F5_SWAP = 5'b00001;
   localparam logic [4:0] F5_LR   = 5'b00010;
   localparam logic [4:0] F5_SC   = 5'b00011;
   localparam logic [4:0] F5_XOR  = 5'b00100;
   localparam logic [4:0] F5_OR   = 5'b01000;
   localparam logic [4:0] F5_AND  = 5'b01100;
   localparam logic [4:0] F5_MIN  = 5'b10000;
   localparam logic [4:0] F5_MAX  = 5'b10100;
   localparam logic [4:0] F5_MINU = 5'b11000;
   localparam logic [4:0] F5_MAXU = 5'b11100;

   typedef enum logic [2:0] {
      AMO_IDLE,
      AMO_RD_REQ,
      AMO_RD_WAIT,
      AMO_WR_REQ,
      AMO_DONE,
      AMO_FAULT
   } amo_state_t;

   function automatic logic is_amo(input logic [4:0] f5);
      case (f5)
         F5_ADD, F5_SWAP, F5_XOR, F5_OR, F5_AND,
         F5_MIN, F5_MAX, F5_MINU, F5_MAXU: is_amo = 1'b1;
         default:                          is_amo = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/amo_alu.sv
// Read-modify-write arithmetic for AMO instructions. For .W the low 32 bits
// are operated on and the write data is zero-padded in the upper half.
module amo_alu
   import riscv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] old_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      funct5_i,
   input  logic            word_i,
   output logic [XLEN-1:0] wdata_o
);

   logic            lt_s;
   logic            lt_u;
   logic [XLEN-1:0] r;

   always_comb begin
      if (word_i) begin
         lt_s = $signed(old_i[31:0]) < $signed(rs2_i[31:0]);
         lt_u = old_i[31:0] < rs2_i[31:0];
      end else begin
         lt_s = $signed(old_i) < $signed(rs2_i);
         lt_u = old_i < rs2_i;
      end

      // Full-width ops are fine for .W: only the low half survives the padding.
      case (funct5_i)
         F5_ADD:  r = old_i + rs2_i;
         F5_XOR:  r = old_i ^ rs2_i;
         F5_OR:   r = old_i | rs2_i;
         F5_AND:  r = old_i & rs2_i;
         F5_MIN:  r = lt_s ? old_i : rs2_i;
         F5_MAX:  r = lt_s ? rs2_i : old_i;
         F5_MINU: r = lt_u ? old_i : rs2_i;
         F5_MAXU: r = lt_u ? rs2_i : old_i;
         default: r = rs2_i;
      endcase

      wdata_o = word_i ? {{(XLEN-32){1'b0}}, r[31:0]} : r;
   end

endmodule

// File: rtl/amo_sequencer.sv
// MEM-stage sequencer for RV64A LR/SC/AMO: runs the bus read-modify-write,
// tracks the LR/SC reservation and stalls the pipeline until retirement.
module amo_sequencer
   import riscv_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [4:0]        funct5_i,
   input  logic              word_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [XLEN-1:0]   rs2_i,
   output logic              memReq_o,
   output logic              memWe_o,
   output logic              memWord_o,
   output logic [ADDR_W-1:0] memAddr_o,
   output logic [XLEN-1:0]   memWdata_o,
   input  logic              memGnt_i,
   input  logic              memRvalid_i,
   input  logic [XLEN-1:0]   memRdata_i,
   input  logic              snoopValid_i,
   input  logic [ADDR_W-1:0] snoopAddr_i,
   input  logic              flushResv_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [XLEN-1:0]   result_o,
   output logic              misaligned_o
);

   localparam int GW = ADDR_W - 3;

   amo_state_t        state_q;
   logic [4:0]        funct5_q;
   logic              word_q;
   logic [GW-1:0]     gran_q;
   logic [XLEN-1:0]   rs2_q;
   logic              resv_valid_q;
   logic [GW-1:0]     resv_gran_q;
   logic              mem_req_q, mem_we_q, mem_word_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [XLEN-1:0]   mem_wdata_q;
   logic              done_q, misaligned_q;
   logic [XLEN-1:0]   result_q;

   logic              misaligned_d;
   logic              sc_hit_d;
   logic              sc_issue_d;
   logic              resv_set_d;
   logic              resv_clr_d;
   logic [GW-1:0]     resv_cmp_gran_d;
   logic [XLEN-1:0]   old_ext_d;
   logic [XLEN-1:0]   alu_wdata_d;
   logic [XLEN-1:0]   sc_wdata_d;

   amo_alu #(.XLEN(XLEN)) u_alu (
      .old_i    (memRdata_i),
      .rs2_i    (rs2_q),
      .funct5_i (funct5_q),
      .word_i   (word_q),
      .wdata_o  (alu_wdata_d)
   );

   always_comb begin
      misaligned_d    = word_i ? (addr_i[1:0] != 2'b00) : (addr_i[2:0] != 3'b000);
      sc_hit_d        = resv_valid_q && (resv_gran_q == addr_i[ADDR_W-1:3]);
      sc_issue_d      = (state_q == AMO_IDLE) && start_i && (funct5_i == F5_SC) && !misaligned_d;
      resv_set_d      = (state_q == AMO_RD_WAIT) && memRvalid_i && (funct5_q == F5_LR);
      // A snoop that hits the granule being reserved this cycle must still win.
      resv_cmp_gran_d = resv_set_d ? gran_q : resv_gran_q;
      resv_clr_d      = flushResv_i || sc_issue_d ||
                        (snoopValid_i && ((snoopAddr_i >> 3) == ADDR_W'(resv_cmp_gran_d)));
      old_ext_d       = word_q ? {{(XLEN-32){memRdata_i[31]}}, memRdata_i[31:0]} : memRdata_i;
      sc_wdata_d      = word_i ? {{(XLEN-32){1'b0}}, rs2_i[31:0]} : rs2_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= AMO_IDLE;
         funct5_q     <= '0;
         word_q       <= 1'b0;
         gran_q       <= '0;
         rs2_q        <= '0;
         resv_valid_q <= 1'b0;
         resv_gran_q  <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_word_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         result_q     <= '0;
      end else begin
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;

         if (resv_clr_d) begin
            resv_valid_q <= 1'b0;
         end else if (resv_set_d) begin
            resv_valid_q <= 1'b1;
            resv_gran_q  <= gran_q;
         end

         case (state_q)
            AMO_IDLE: begin
               if (start_i) begin
                  funct5_q   <= funct5_i;
                  word_q     <= word_i;
                  gran_q     <= addr_i[ADDR_W-1:3];
                  rs2_q      <= rs2_i;
                  mem_word_q <= word_i;
                  mem_addr_q <= addr_i;
                  if (misaligned_d) begin
                     state_q      <= AMO_FAULT;
                     misaligned_q <= 1'b1;
                  end else if (funct5_i == F5_LR || is_amo(funct5_i)) begin
                     state_q   <= AMO_RD_REQ;
                     mem_req_q <= 1'b1;
                     mem_we_q  <= 1'b0;
                  end else if (funct5_i == F5_SC && sc_hit_d) begin
                     state_q     <= AMO_WR_REQ;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b1;
                     mem_wdata_q <= sc_wdata_d;
                  end else begin
                     state_q  <= AMO_DONE;
                     done_q   <= 1'b1;
                     result_q <= {{(XLEN-1){1'b0}}, (funct5_i == F5_SC)};
                  end
               end
            end
            AMO_RD_REQ: begin
               if (memGnt_i) begin
                  mem_req_q <= 1'b0;
                  state_q   <= AMO_RD_WAIT;
               end
            end
            AMO_RD_WAIT: begin
               if (memRvalid_i) begin
                  result_q <= old_ext_d;
                  if (funct5_q == F5_LR) begin
                     state_q <= AMO_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= AMO_WR_REQ;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b1;
                     mem_wdata_q <= alu_wdata_d;
                  end
               end
            end
            AMO_WR_REQ: begin
               if (memGnt_i) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state_q   <= AMO_DONE;
                  done_q    <= 1'b1;
                  if (funct5_q == F5_SC) result_q <= '0;
               end
            end
            default: state_q <= AMO_IDLE;
         endcase
      end
   end

   assign stall_o      = ((state_q == AMO_IDLE) && start_i) ||
                         (state_q == AMO_RD_REQ) || (state_q == AMO_RD_WAIT) ||
                         (state_q == AMO_WR_REQ);
   assign memReq_o     = mem_req_q;
   assign memWe_o      = mem_we_q;
   assign memWord_o    = mem_word_q;
   assign memAddr_o    = mem_addr_q;
   assign memWdata_o   = mem_wdata_q;
   assign done_o       = done_q;
   assign result_o     = result_q;
   assign misaligned_o = misaligned_q;

endmodule

// File: doc/amo_sequencer.md
# amo_sequencer

Multi-cycle sequencer for RV64A instructions (LR, SC, AMO*) in the MEM stage. It runs the read-modify-write memory transaction, keeps the LR/SC reservation and produces the rd result. It drives the `coprocessorStall` input of the controller, which holds the pipeline until the operation retires. The atomic ALU decode still comes from the controller. This block owns only the memory-side sequencing and the read-modify-write arithmetic.

## Interface
- XLEN, 64, data width
- ADDR_W, 64, address width
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start_i  in  1  valid atomic instruction in MEM; sampled only in IDLE
- funct5_i  in  5  instr[31:27]
- word_i  in  1  1 = .W (32-bit), 0 = .D
- addr_i  in  ADDR_W  rs1 address
- rs2_i  in  XLEN  store/operand value
- memReq_o  out  1  bus request; held until granted
- memWe_o  out  1  1 = write
- memWord_o  out  1  access size (mirrors word_i)
- memAddr_o  out  ADDR_W  bus address
- memWdata_o  out  XLEN  write data
- memGnt_i  in  1  request accepted this cycle; writes complete on grant
- memRvalid_i  in  1  read data valid; at least 1 cycle after grant
- memRdata_i  in  XLEN  read data
- snoopValid_i  in  1  another agent's store observed
- snoopAddr_i  in  ADDR_W  address of that store
- flushResv_i  in  1  trap/xRET; clears the reservation
- stall_o  out  1  maps to controller coprocessorStall
- done_o  out  1  one-cycle retire pulse
- result_o  out  XLEN  rd value, valid while done_o is high
- misaligned_o  out  1  one-cycle fault pulse; no bus access is made

## Operation
- funct5 encodings: ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
- Any other funct5 retires with result 0. This case does not occur because maindec traps it.
- States:
  - IDLE: on start_i:
    - misaligned address (.W addr[1:0]≠0, .D addr[2:0]≠0) → FAULT
    - LR or AMO → RD_REQ
    - SC with reservation valid and match → WR_REQ
    - SC otherwise → DONE with result 1
  - RD_REQ: on memGnt_i → RD_WAIT.
  - RD_WAIT: on memRvalid_i, latch the data:
    - LR: set the reservation → DONE
    - AMO: → WR_REQ
  - WR_REQ: on memGnt_i → DONE. For SC, result 0.
  - DONE: done_o=1 → IDLE.
  - FAULT: misaligned_o=1 → IDLE.
- Operands and result:
  - Operands and request fields are latched at start.
  - result_o for LR/AMO is the old memory value.
  - For .W, that value is the low 32 bits sign-extended.
  - AMO compute for .W uses the low 32 bits, with 32-bit signed/unsigned compare.
  - The .W write data is zero-padded in the upper half.
- Reservation:
  - Valid bit plus addr[ADDR_W-1:3] (8-byte granule).
  - Cleared by reset, flushResv_i, every SC (pass or fail), and snoopValid_i with a matching granule.
  - If a clear and an LR set happen in the same cycle, the clear wins.
- stall_o = (state IDLE & start_i) | state ∈ {RD_REQ, RD_WAIT, WR_REQ}.
- stall_o is low in DONE and FAULT, so the pipeline advances in the same cycle as the pulse.

## Timing
- Reset values: state IDLE, all outputs 0, reservation invalid. Reset mid-transaction drops memReq_o at once with no write.
- Latencies with single-cycle grant and rvalid 1 cycle after grant:
  - SC fail or FAULT: 2 cycles, start to pulse.
  - SC pass: 3 cycles.
  - LR: 4 cycles.
  - AMO: 5 cycles.
- memReq_o, memWe_o, memAddr_o and memWdata_o are registered and stable from assertion until grant.
- Bus ordering:
  - Only one request is outstanding at a time.
  - memRvalid_i outside RD_WAIT is ignored.
  - memGnt_i while memReq_o is low is ignored.
- start_i outside IDLE is ignored.
- snoopValid_i during an AMO does not abort it (the AMO is atomic at the bus).

## Structure
- Put these in the shared `riscv_pkg`:
  - the funct5 localparams
  - the `amo_state_t` enum
- Sub-module `amo_alu` (combinational): old value, rs2, funct5 and word in; write data out.
- FSM, reservation and bus registers stay in `amo_sequencer`.

## Test plan
- AMOADD.D addr 0x100, mem 0x5, rs2 0x3, grant delayed 2 cycles → stall_o held throughout; write 0x8 to 0x100; result 0x5; done_o for 1 cycle.
- AMOMIN.W mem 0x8000_0000, rs2 0x1 → write 0x8000_0000; result 0xFFFF_FFFF_8000_0000.
- AMOMINU.W with the same operands → write 0x1.
- LR.D 0x200 then SC.D 0x200, rs2 0xAA:
  - → write 0xAA; result 0.
  - A second SC.D 0x200 → no bus access; result 1.
- LR.D 0x200, then snoopValid_i with 0x204, then SC.D 0x200 → SC fails (result 1). Repeat with snoop address 0x208 → SC succeeds.
- AMOSWAP.W at 0x102 → misaligned_o pulse, no memReq_o. Separately, reset_n low during RD_WAIT → all outputs 0, reservation invalid.
